// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bundle for the InvMixColumns stage: input state in, transformed state out.
interface inv_mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: captures a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, then presents the result.

module inv_mix_col (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] a, x2, x4, x8, m9, m11, m13, m14;

  // byte0 sits in the top byte of the column word
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      a[k]   = col_i[31 - 8*k -: 8];
      x2[k]  = xtime(a[k]);
      x4[k]  = xtime(x2[k]);
      x8[k]  = xtime(x4[k]);
      m9[k]  = x8[k] ^ a[k];
      m11[k] = x8[k] ^ x2[k] ^ a[k];
      m13[k] = x8[k] ^ x4[k] ^ a[k];
      m14[k] = x8[k] ^ x4[k] ^ x2[k];
    end
  end

  assign col_o[31:24] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
  assign col_o[23:16] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
  assign col_o[15:8]  = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
  assign col_o[7:0]   = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
endmodule

module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inv_mix_columns_seq_if.slave bus
);
  localparam int N = COLS_PER_CYCLE;

  if (!(N == 1 || N == 2 || N == 4)) begin : g_bad_param
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Step wraps to 0 for N=4, so the counter never leaves 0 in that build.
  localparam logic [1:0] STEP = 2'(N % 4);
  localparam logic [1:0] LAST = 2'(4 - N);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0][31:0] work_q, work_d;
  logic [127:0]    out_q, out_d;

  logic [N-1:0][1:0]  lane_col;
  logic [N-1:0][31:0] lane_in, lane_out;

  // column c lives in word 3-c so that column 0 is the most significant
  for (genvar l = 0; l < N; l++) begin : g_lane
    assign lane_col[l] = cnt_q + 2'(l);
    assign lane_in[l]  = work_q[2'd3 - lane_col[l]];
    inv_mix_col u_col (
      .col_i (lane_in[l]),
      .col_o (lane_out[l])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_data;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int l = 0; l < N; l++) work_d[2'd3 - lane_col[l]] = lane_out[l];
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST) begin
          out_d   = work_d;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_data  = out_q;
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: one instance each of 1, 2 and 4 columns per cycle.
module tb_inv_mix_columns_seq;
  logic clk, rst_n;
  logic         iv [3];
  logic         orr[3];
  logic [127:0] idat[3];
  logic         ir [3];
  logic         ov [3];
  logic [127:0] od [3];

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    inv_mix_columns_seq_if bus ();
    assign bus.in_valid  = iv[g];
    assign bus.in_data   = idat[g];
    assign bus.out_ready = orr[g];
    assign ir[g] = bus.in_ready;
    assign ov[g] = bus.out_valid;
    assign od[g] = bus.out_data;
    inv_mix_columns_seq #(.COLS_PER_CYCLE(NC)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  // Reference: GF(2^8) product by shift-and-add followed by polynomial reduction.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Circulant matrix multiply per column; inv selects InvMixColumns vs MixColumns.
  function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
    logic [7:0]   coef[4];
    logic [7:0]   a[4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) begin
      coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
    end else begin
      coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - row + 4) % 4], a[k]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 2 : 1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One transaction; input is trashed right after accept, optional back-pressure hold.
  task automatic run_tx(input int d, input logic [127:0] din, input logic [127:0] expv,
                        input int hold, input string nm);
    int  lat;
    bit  stable;
    int  w;
    w = 0;
    while (!ir[d] && w < 20) begin
      @(posedge clk); @(negedge clk);
      w++;
    end
    chk({nm, "/idle_wait"}, 128'(ir[d]), 128'd1);
    iv[d] = 1'b1; idat[d] = din;
    @(posedge clk); @(negedge clk);
    iv[d] = 1'b0; idat[d] = '1;
    chk({nm, "/busy_in_ready"}, 128'(ir[d]), 128'd0);
    lat = 0;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); @(negedge clk);
      if (ov[d]) begin lat = j; break; end
    end
    chk({nm, "/latency"}, 128'(lat), 128'(lat_of(d)));
    chk({nm, "/result"}, od[d], expv);
    if (hold > 0) begin
      stable = 1'b1;
      iv[d] = 1'b1; idat[d] = rnd128();
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); @(negedge clk);
        if (!ov[d] || ir[d] || od[d] !== expv) stable = 1'b0;
      end
      iv[d] = 1'b0;
      chk({nm, "/hold_stable"}, 128'(stable), 128'd1);
    end
    orr[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    orr[d] = 1'b0;
    chk({nm, "/valid_drop"}, 128'(ov[d]), 128'd0);
    chk({nm, "/ready_back"}, 128'(ir[d]), 128'd1);
    chk({nm, "/out_held"}, od[d], expv);
  endtask

  task automatic back_to_back(input int d);
    logic [127:0] s[3];
    int  sent, got, lastc;
    bit  acc;
    for (int i = 0; i < 3; i++) s[i] = rnd128();
    sent = 0; got = 0; lastc = 0;
    idat[d] = s[0]; iv[d] = 1'b1; orr[d] = 1'b1;
    for (int c = 0; c < 200 && got < 3; c++) begin
      acc = ir[d] && iv[d];
      if (ov[d]) begin
        chk($sformatf("b2b%0d/result%0d", d, got), od[d], mix_model(s[got], 1'b1));
        if (got > 0)
          chk($sformatf("b2b%0d/spacing%0d", d, got), 128'(c - lastc), 128'(lat_of(d) + 2));
        lastc = c;
        got++;
      end
      @(posedge clk); @(negedge clk);
      if (acc) begin
        sent++;
        if (sent < 3) idat[d] = s[sent];
        else iv[d] = 1'b0;
      end
    end
    iv[d] = 1'b0; orr[d] = 1'b0;
    chk($sformatf("b2b%0d/count", d), 128'(got), 128'd3);
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    string        nm;
  } vec_t;

  localparam logic [127:0] T1_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] T1_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[4];
    logic [127:0] orig;
    tbl[0] = '{T1_IN, T1_OUT, "fips"};
    tbl[1] = '{128'h0, 128'h0, "zero"};
    tbl[2] = '{{4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}, "c6"};
    tbl[3] = '{128'h4d7ebdf8_9fdc589d_c6c6c6c6_01010101,
               128'h2d26314c_f20a225c_c6c6c6c6_01010101, "col_mix"};

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; orr[d] = 1'b0; idat[d] = '0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset%0d/out_valid", d), 128'(ov[d]), 128'd0);
      chk($sformatf("reset%0d/out_data", d), od[d], 128'd0);
      chk($sformatf("reset%0d/in_ready", d), 128'(ir[d]), 128'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 4; i++)
        run_tx(d, tbl[i].din, tbl[i].dout, 0, $sformatf("%s_n%0d", tbl[i].nm, d));

    // Back-pressure with an ignored IN_VALID pulse while DONE
    for (int d = 0; d < 3; d++)
      run_tx(d, T1_IN, T1_OUT, 20, $sformatf("bp_n%0d", d));

    // Asynchronous reset in the second BUSY cycle of the 1-column build
    iv[0] = 1'b1; idat[0] = T1_IN;
    @(posedge clk); @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort/out_valid", 128'(ov[0]), 128'd0);
    chk("abort/out_data", od[0], 128'd0);
    chk("abort/in_ready", 128'(ir[0]), 128'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_tx(0, T1_IN, T1_OUT, 0, "after_abort");

    for (int d = 0; d < 3; d++) back_to_back(d);

    for (int i = 0; i < 1000; i++) begin
      orig = rnd128();
      run_tx(i % 3, mix_model(orig, 1'b0), orig, 0, $sformatf("rt%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
